// File: rtl/tt_seq_pkg.sv
// Shared definitions for the phase sequencer: FSM state encoding, phase-width
// helper and the bit positions of the packed io_out bus.
package tt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  // io_out bit positions; the phase field occupies [OUT_PHASE_MSB:OUT_PHASE_LSB]
  localparam int OUT_PHASE_LSB = 0;
  localparam int OUT_PHASE_MSB = 2;
  localparam int OUT_STEP      = 3;
  localparam int OUT_REQ_PEND  = 4;
  localparam int OUT_RUNNING   = 5;
  localparam int OUT_WRAP      = 6;
  localparam int OUT_HELD      = 7;

  // Width of the phase register; never narrower than one bit.
  function automatic int phase_w(input int phases);
    return (phases <= 2) ? 1 : $clog2(phases);
  endfunction

endpackage

// File: rtl/tt_seq_dwell_counter.sv
// Loadable dwell down-counter. Freeze has priority over load, load over
// decrement; the count stops at zero and tc flags the terminal count.
module tt_seq_dwell_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic             freeze,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Counter register: frozen, reloaded or decremented toward zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/tt_phase_sequencer.sv
// Phase sequencer: steps through PHASES phases, each lasting DWELL+ext clocks,
// with a sticky skip-to-phase-0 request and a run/hold control.
// Build option: define SEQ_GRAY_OUT_EN to present the phase index on
// io_out[2:0] as Gray code instead of plain binary.
module tt_phase_sequencer
  import tt_seq_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int DWELL  = 3,
  parameter int CNT_W  = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int PW = phase_w(PHASES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       req;
  logic       dir;
  logic [2:0] ext;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign run   = io_in[2];
  assign req   = io_in[3];
  assign dir   = io_in[4];
  assign ext   = io_in[7:5];

  seq_state_e       state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             req_pend_q, req_pend_d;
  logic             step_d, wrap_d;
  logic             cnt_load, cnt_dec, cnt_freeze, cnt_tc;
  logic [CNT_W-1:0] load_val;
  logic [PW-1:0]    phase_adv;
  logic [2:0]       phase_bin, phase_enc;
  logic [7:0]       out_d, out_q;

  // Reload value is re-sampled from ext at every load.
  assign load_val = CNT_W'(DWELL - 1) + CNT_W'(ext);

  // Neighbouring phase in the selected direction, wrapping modulo PHASES.
  assign phase_adv = dir ? ((phase_q == '0) ? LAST_PHASE : phase_q - PW'(1))
                         : ((phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1));

  tt_seq_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .freeze   (cnt_freeze),
    .load_val (load_val),
    .tc       (cnt_tc)
  );

  // Next-state, counter control and strobe decode.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    req_pend_d = req_pend_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_freeze = 1'b0;
    step_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_pend_d = req_pend_q | req;
        if (run) begin
          state_d  = RUN;
          phase_d  = '0;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          // Everything frozen, pending request left for later.
          state_d    = HOLD;
          cnt_freeze = 1'b1;
        end else if (req_pend_q) begin
          // Serve the pending request; a new req this cycle re-arms it.
          cnt_load   = 1'b1;
          req_pend_d = req;
          if (phase_q != '0) begin
            phase_d = '0;
            step_d  = 1'b1;
          end
        end else begin
          req_pend_d = req;
          if (cnt_tc) begin
            phase_d  = phase_adv;
            cnt_load = 1'b1;
            step_d   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      HOLD: begin
        cnt_freeze = 1'b1;
        if (req) begin
          state_d    = IDLE;
          phase_d    = '0;
          req_pend_d = 1'b0;
        end else if (run) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = IDLE;
        phase_d    = '0;
        req_pend_d = 1'b0;
      end
    endcase
    wrap_d = (phase_d == '0) && (phase_q != '0);
  end

  // Output encoding of the next phase, so the io_out register holds it directly.
  assign phase_bin = 3'(phase_d);
`ifdef SEQ_GRAY_OUT_EN
  assign phase_enc = phase_bin ^ (phase_bin >> 1);
`else
  assign phase_enc = phase_bin;
`endif

  // Assemble the registered output word from next-state values.
  always_comb begin
    out_d                              = '0;
    out_d[OUT_PHASE_MSB:OUT_PHASE_LSB] = phase_enc;
    out_d[OUT_STEP]                    = step_d;
    out_d[OUT_REQ_PEND]                = req_pend_d;
    out_d[OUT_RUNNING]                 = (state_d == RUN);
    out_d[OUT_WRAP]                    = wrap_d;
    out_d[OUT_HELD]                    = (state_d == HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      req_pend_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      req_pend_q <= req_pend_d;
      out_q      <= out_d;
    end
  end

  assign io_out = out_q;

endmodule
